ahb_sram_bist_mux: RTL and testbench

//  Sits between the AHB-to-SRAM bridge SRAM port and the SRAM macro.
//  In normal mode it passes bridge accesses straight through.
//  On request it runs a March C- self-test over every SRAM word and

---
 rtl/ahb_sram_bist_mux.sv | 217 +++++++++++++++++++++
 tb/tb_ahb_sram_bist_mux.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_sram_bist_mux.sv
// ahb_sram_bist_mux
//   Sits between the AHB-to-SRAM bridge SRAM port and the SRAM macro.
//   In normal mode, bridge accesses pass straight through with no added latency.
//   When BIST_START is sampled high while idle, the block runs a March C-
//   self-test over every word and takes the macro away from the bridge.
//   When the run ends, the block reports pass/fail and the first failing
//   word address.
// Ports
//   HCLK, HRESETn            clock, asynchronous active-low reset
//   BIST_START               start request (ignored while BIST_BUSY)
//   BIST_BUSY/DONE/FAIL      run status; DONE and FAIL held until next start
//   BIST_FAILADDR            word address of the first mismatch
//   SRAM*                    bridge side (SRAMRDATA mirrors MEMRDATA)
//   MEM*                     macro side, 1-cycle read latency
module ahb_sram_bist_mux #(
  parameter int AW = 16
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          BIST_START,
  output logic          BIST_BUSY,
  output logic          BIST_DONE,
  output logic          BIST_FAIL,
  output logic [AW-3:0] BIST_FAILADDR,
  input  logic [AW-3:0] SRAMADDR,
  input  logic [3:0]    SRAMWEN,
  input  logic [31:0]   SRAMWDATA,
  input  logic          SRAMCS,
  output logic [31:0]   SRAMRDATA,
  output logic [AW-3:0] MEMADDR,
  output logic [3:0]    MEMWEN,
  output logic [31:0]   MEMWDATA,
  output logic          MEMCS,
  input  logic [31:0]   MEMRDATA
);

  localparam logic [AW-3:0] ADDR_LAST = {(AW-2){1'b1}};
  localparam logic [AW-3:0] ADDR_ZERO = '0;
  localparam logic [31:0]   D0 = 32'h0000_0000;
  localparam logic [31:0]   D1 = 32'hFFFF_FFFF;

  typedef enum logic [3:0] {
    IDLE, M0_W, M1_R, M1_W, M2_R, M2_W, M3_R, M3_W,
    M4_R, M4_W, M5_R, CMP_LAST, DONE
  } state_t;

  state_t        state_reg, state_next;
  logic [AW-3:0] addr_reg, addr_next;
  logic          busy_reg, done_reg, fail_reg;
  logic [AW-3:0] failaddr_reg;
  logic          cmp_valid_reg;
  logic [31:0]   exp_data_reg;
  logic [AW-3:0] exp_addr_reg;

  logic          bist_cs;
  logic [3:0]    bist_wen;
  logic [31:0]   bist_wdata;
  logic          is_read;
  logic [31:0]   exp_data_next;
  logic          start_ok;
  logic          mismatch;

  assign start_ok = BIST_START && !busy_reg;
  assign mismatch = cmp_valid_reg && (MEMRDATA != exp_data_reg);

  // State register plus run status, address counter and compare pipeline
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      fail_reg      <= 1'b0;
      failaddr_reg  <= '0;
      cmp_valid_reg <= 1'b0;
      exp_data_reg  <= '0;
      exp_addr_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      // A read this cycle is checked against MEMRDATA next cycle
      cmp_valid_reg <= is_read;
      exp_data_reg  <= exp_data_next;
      exp_addr_reg  <= addr_reg;
      if (start_ok) begin
        busy_reg     <= 1'b1;
        done_reg     <= 1'b0;
        fail_reg     <= 1'b0;
        failaddr_reg <= '0;
      end else begin
        if (state_reg == CMP_LAST) begin
          busy_reg <= 1'b0;
          done_reg <= 1'b1;
        end
        // Only the first mismatch records its address; the run continues
        if (mismatch && !fail_reg) begin
          fail_reg     <= 1'b1;
          failaddr_reg <= exp_addr_reg;
        end
      end
    end
  end

  // Next state and address; terminal addresses use explicit compares
  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (start_ok) begin
          state_next = M0_W;
          addr_next  = ADDR_ZERO;
        end
      end
      M0_W: begin
        if (addr_reg == ADDR_LAST) begin
          state_next = M1_R;
          addr_next  = ADDR_ZERO;
        end else begin
          addr_next = addr_reg + 1'b1;
        end
      end
      M1_R: state_next = M1_W;
      M1_W: begin
        if (addr_reg == ADDR_LAST) begin
          state_next = M2_R;
          addr_next  = ADDR_ZERO;
        end else begin
          state_next = M1_R;
          addr_next  = addr_reg + 1'b1;
        end
      end
      M2_R: state_next = M2_W;
      M2_W: begin
        if (addr_reg == ADDR_LAST) begin
          state_next = M3_R;
          addr_next  = ADDR_LAST;
        end else begin
          state_next = M2_R;
          addr_next  = addr_reg + 1'b1;
        end
      end
      M3_R: state_next = M3_W;
      M3_W: begin
        if (addr_reg == ADDR_ZERO) begin
          state_next = M4_R;
          addr_next  = ADDR_LAST;
        end else begin
          state_next = M3_R;
          addr_next  = addr_reg - 1'b1;
        end
      end
      M4_R: state_next = M4_W;
      M4_W: begin
        if (addr_reg == ADDR_ZERO) begin
          state_next = M5_R;
          addr_next  = ADDR_ZERO;
        end else begin
          state_next = M4_R;
          addr_next  = addr_reg - 1'b1;
        end
      end
      M5_R: begin
        if (addr_reg == ADDR_LAST) begin
          state_next = CMP_LAST;
        end else begin
          addr_next = addr_reg + 1'b1;
        end
      end
      CMP_LAST: state_next = DONE;
      default:  state_next = IDLE;
    endcase
  end

  // Per-state memory access and expected read data
  always_comb begin
    bist_cs       = 1'b0;
    bist_wen      = 4'h0;
    bist_wdata    = D0;
    is_read       = 1'b0;
    exp_data_next = D0;
    case (state_reg)
      M0_W, M2_W, M4_W: begin
        bist_cs  = 1'b1;
        bist_wen = 4'hF;
      end
      M1_W, M3_W: begin
        bist_cs    = 1'b1;
        bist_wen   = 4'hF;
        bist_wdata = D1;
      end
      M1_R, M3_R, M5_R: begin
        bist_cs = 1'b1;
        is_read = 1'b1;
      end
      M2_R, M4_R: begin
        bist_cs       = 1'b1;
        is_read       = 1'b1;
        exp_data_next = D1;
      end
      default: ;
    endcase
  end

  // Combinational port mux: bridge traffic is dropped while the test owns the macro
  assign MEMADDR  = busy_reg ? addr_reg   : SRAMADDR;
  assign MEMWEN   = busy_reg ? bist_wen   : SRAMWEN;
  assign MEMWDATA = busy_reg ? bist_wdata : SRAMWDATA;
  assign MEMCS    = busy_reg ? bist_cs    : SRAMCS;
  assign SRAMRDATA = MEMRDATA;

  assign BIST_BUSY     = busy_reg;
  assign BIST_DONE     = done_reg;
  assign BIST_FAIL     = fail_reg;
  assign BIST_FAILADDR = failaddr_reg;

endmodule

// File: tb/tb_ahb_sram_bist_mux.sv
module tb_ahb_sram_bist_mux;
  localparam int AW = 6;
  localparam int N  = 16;
  localparam int RUN_CYCLES = 10 * N + 1;

  logic          HCLK;
  logic          HRESETn;
  logic          BIST_START;
  logic          BIST_BUSY, BIST_DONE, BIST_FAIL;
  logic [AW-3:0] BIST_FAILADDR;
  logic [AW-3:0] SRAMADDR;
  logic [3:0]    SRAMWEN;
  logic [31:0]   SRAMWDATA;
  logic          SRAMCS;
  logic [31:0]   SRAMRDATA;
  logic [AW-3:0] MEMADDR;
  logic [3:0]    MEMWEN;
  logic [31:0]   MEMWDATA;
  logic          MEMCS;
  logic [31:0]   MEMRDATA;

  int tests = 0;
  int fails = 0;

  // Behavioural SRAM with per-word stuck-at masks applied on read
  logic [31:0] mem [N];
  logic [31:0] sa1 [N];
  logic [31:0] sa0 [N];

  ahb_sram_bist_mux #(.AW(AW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .BIST_START(BIST_START),
    .BIST_BUSY(BIST_BUSY), .BIST_DONE(BIST_DONE), .BIST_FAIL(BIST_FAIL),
    .BIST_FAILADDR(BIST_FAILADDR),
    .SRAMADDR(SRAMADDR), .SRAMWEN(SRAMWEN), .SRAMWDATA(SRAMWDATA),
    .SRAMCS(SRAMCS), .SRAMRDATA(SRAMRDATA),
    .MEMADDR(MEMADDR), .MEMWEN(MEMWEN), .MEMWDATA(MEMWDATA),
    .MEMCS(MEMCS), .MEMRDATA(MEMRDATA)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  always @(posedge HCLK) begin
    if (MEMCS) begin
      if (MEMWEN != 4'h0) begin
        for (int b = 0; b < 4; b++)
          if (MEMWEN[b]) mem[MEMADDR][b*8 +: 8] <= MEMWDATA[b*8 +: 8];
      end else begin
        MEMRDATA <= (mem[MEMADDR] | sa1[MEMADDR]) & ~sa0[MEMADDR];
      end
    end
  end

  task automatic clear_faults();
    for (int i = 0; i < N; i++) begin
      sa1[i] = 32'h0;
      sa0[i] = 32'h0;
    end
  endtask

  task automatic bridge_idle();
    SRAMCS = 1'b0; SRAMWEN = 4'h0; SRAMADDR = '0; SRAMWDATA = 32'h0;
  endtask

  task automatic check_mirror(input string name);
    tests++;
    if (MEMADDR !== SRAMADDR || MEMWEN !== SRAMWEN || MEMWDATA !== SRAMWDATA || MEMCS !== SRAMCS) begin
      fails++;
      $display("FAIL %s: mem addr=%0h wen=%0h wdata=%08h cs=%0b, required %0h %0h %08h %0b",
               name, MEMADDR, MEMWEN, MEMWDATA, MEMCS, SRAMADDR, SRAMWEN, SRAMWDATA, SRAMCS);
    end else
      $display("[TB] %s: mirror ok addr=%0h wen=%0h cs=%0b", name, MEMADDR, MEMWEN, MEMCS);
  endtask

  // Pulses (or holds) START, checks cleared flags, counts BUSY cycles and final status
  task automatic run_bist(input string name, input bit hold, input bit exp_fail,
                          input logic [AW-3:0] exp_addr);
    int cnt;
    @(posedge HCLK); #1 BIST_START = 1'b1;
    @(posedge HCLK); #1 if (!hold) BIST_START = 1'b0;
    #1;
    tests++;
    if (BIST_BUSY !== 1'b1 || BIST_DONE !== 1'b0 || BIST_FAIL !== 1'b0 || BIST_FAILADDR !== '0) begin
      fails++;
      $display("FAIL %s_start: busy=%0b done=%0b fail=%0b faddr=%0d, required 1 0 0 0",
               name, BIST_BUSY, BIST_DONE, BIST_FAIL, BIST_FAILADDR);
    end else
      $display("[TB] %s_start: busy=1 done=0 fail=0", name);
    cnt = 0;
    while (BIST_BUSY === 1'b1 && cnt < 400) begin
      cnt++;
      @(posedge HCLK); #2;
    end
    BIST_START = 1'b0;
    tests++;
    if (cnt != RUN_CYCLES) begin
      fails++;
      $display("FAIL %s_cycles: busy cycles=%0d, required %0d", name, cnt, RUN_CYCLES);
    end else
      $display("[TB] %s_cycles: busy cycles=%0d", name, cnt);
    tests++;
    if (BIST_DONE !== 1'b1 || BIST_FAIL !== exp_fail || (exp_fail && BIST_FAILADDR !== exp_addr)) begin
      fails++;
      $display("FAIL %s_result: done=%0b fail=%0b faddr=%0d, required 1 %0b %0d",
               name, BIST_DONE, BIST_FAIL, BIST_FAILADDR, exp_fail, exp_addr);
    end else
      $display("[TB] %s_result: done=1 fail=%0b faddr=%0d", name, BIST_FAIL, BIST_FAILADDR);
    // A held-over START must not have restarted the test
    @(posedge HCLK); #2;
    tests++;
    if (BIST_BUSY !== 1'b0 || BIST_DONE !== 1'b1) begin
      fails++;
      $display("FAIL %s_after: busy=%0b done=%0b, required 0 1", name, BIST_BUSY, BIST_DONE);
    end else
      $display("[TB] %s_after: idle and done", name);
  endtask

  task automatic test_reset();
    HRESETn = 1'b0; BIST_START = 1'b0; bridge_idle(); clear_faults();
    for (int i = 0; i < N; i++) mem[i] = 32'h1111_1111 * i;
    repeat (2) @(posedge HCLK);
    #2;
    tests++;
    if (BIST_BUSY !== 1'b0 || BIST_DONE !== 1'b0 || BIST_FAIL !== 1'b0 || BIST_FAILADDR !== '0) begin
      fails++;
      $display("FAIL reset: busy=%0b done=%0b fail=%0b faddr=%0d, required 0 0 0 0",
               BIST_BUSY, BIST_DONE, BIST_FAIL, BIST_FAILADDR);
    end else
      $display("[TB] reset: status all zero");
    #3 HRESETn = 1'b1;
  endtask

  task automatic test_passthrough();
    @(posedge HCLK); #1;
    SRAMCS = 1'b1; SRAMWEN = 4'hF; SRAMADDR = 4'd3; SRAMWDATA = 32'hA5A5_1234;
    #1 check_mirror("pass_write");
    @(posedge HCLK); #1;
    SRAMWEN = 4'h0; SRAMWDATA = 32'h0;
    #1 check_mirror("pass_read");
    @(posedge HCLK); #1;
    bridge_idle();
    #1;
    tests++;
    if (SRAMRDATA !== 32'hA5A5_1234) begin
      fails++;
      $display("FAIL pass_rdata: got %08h, required a5a51234", SRAMRDATA);
    end else
      $display("[TB] pass_rdata: %08h", SRAMRDATA);
  endtask

  task automatic test_readback_zero();
    for (int i = 0; i < N; i++) begin
      @(posedge HCLK); #1;
      SRAMCS = 1'b1; SRAMWEN = 4'h0; SRAMADDR = i[AW-3:0];
      @(posedge HCLK); #1;
      bridge_idle();
      #1;
      tests++;
      if (SRAMRDATA !== 32'h0) begin
        fails++;
        $display("FAIL readback[%0d]: got %08h, required 00000000", i, SRAMRDATA);
      end else
        $display("[TB] readback[%0d]: %08h", i, SRAMRDATA);
    end
  endtask

  task automatic test_clean_run();
    clear_faults();
    run_bist("clean", 1'b0, 1'b0, '0);
    test_readback_zero();
  endtask

  task automatic test_stuck_at_one();
    clear_faults();
    sa1[5] = 32'h0000_0008;
    run_bist("sa1_w5", 1'b0, 1'b1, 4'd5);
  endtask

  task automatic test_two_faults();
    clear_faults();
    sa0[9] = 32'h0000_0001;
    sa0[2] = 32'h0000_0001;
    run_bist("sa0_w9_w2", 1'b0, 1'b1, 4'd2);
  endtask

  task automatic test_start_held();
    clear_faults();
    run_bist("held_start", 1'b1, 1'b0, '0);
  endtask

  task automatic test_bridge_dropped();
    // Bridge write during a run must not reach the macro
    @(posedge HCLK); #1 BIST_START = 1'b1;
    @(posedge HCLK); #1 BIST_START = 1'b0;
    SRAMCS = 1'b1; SRAMWEN = 4'hF; SRAMADDR = 4'd7; SRAMWDATA = 32'hDEAD_BEEF;
    repeat (3) begin
      @(posedge HCLK); #2;
      tests++;
      if (MEMWDATA === 32'hDEAD_BEEF || MEMADDR !== dut.addr_reg) begin
        fails++;
        $display("FAIL drop_bridge: mem addr=%0h wdata=%08h leaked bridge values", MEMADDR, MEMWDATA);
      end else
        $display("[TB] drop_bridge: mem addr=%0h wdata=%08h", MEMADDR, MEMWDATA);
    end
    bridge_idle();
  endtask

  task automatic test_reset_mid_run();
    clear_faults();
    sa1[5] = 32'h0000_0008;
    HRESETn = 1'b0; #3 HRESETn = 1'b1;
    @(posedge HCLK); #1 BIST_START = 1'b1;
    @(posedge HCLK); #1 BIST_START = 1'b0;
    repeat (39) @(posedge HCLK);
    #2;
    tests++;
    if (BIST_BUSY !== 1'b1 || BIST_FAIL !== 1'b1) begin
      fails++;
      $display("FAIL mid_run: busy=%0b fail=%0b, required 1 1", BIST_BUSY, BIST_FAIL);
    end else
      $display("[TB] mid_run: busy=1 fail=1 at cycle 40");
    HRESETn = 1'b0;
    #1;
    tests++;
    if (BIST_BUSY !== 1'b0 || BIST_DONE !== 1'b0 || BIST_FAIL !== 1'b0 || MEMCS !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset: busy=%0b done=%0b fail=%0b memcs=%0b, required 0 0 0 0",
               BIST_BUSY, BIST_DONE, BIST_FAIL, MEMCS);
    end else
      $display("[TB] mid_reset: status cleared, macro idle");
    @(posedge HCLK); #2 HRESETn = 1'b1;
    @(posedge HCLK); #1;
    SRAMCS = 1'b1; SRAMWEN = 4'h3; SRAMADDR = 4'd11; SRAMWDATA = 32'h0BAD_F00D;
    #1 check_mirror("post_reset_write");
    @(posedge HCLK); #1;
    SRAMWEN = 4'h0;
    @(posedge HCLK); #1;
    bridge_idle();
    #1;
    tests++;
    if (SRAMRDATA[15:0] !== 16'hF00D) begin
      fails++;
      $display("FAIL post_reset_rdata: got %04h, required f00d", SRAMRDATA[15:0]);
    end else
      $display("[TB] post_reset_rdata: low half %04h", SRAMRDATA[15:0]);
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_clean_run();
    test_stuck_at_one();
    test_two_faults();
    test_start_held();
    test_bridge_dropped();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
